// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM encoding, default width and counter-width helper for serial_add_accum
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/serial_add_accum_ha_cell.sv
// ha_cell: single half-adder cell, two of them plus a carry flop make the serial full adder
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

// File: rtl/serial_add_accum.sv
// serial_add_accum: LSB-first bit-serial adder with done pulse; SERIAL_ADD_SATURATE_EN clamps result to all-ones on carry
module serial_add_accum
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);
  localparam int CW = cnt_w(WIDTH);
  state_t r_state, w_next;
  logic r_carry;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-2:0] r_sr;
  logic [WIDTH-1:0] w_sh, w_res;
  logic w_s0, w_c0, w_sum, w_c1, w_carry_next, w_accept, w_last;
  ha_cell u_ha0 (.a(a_bit), .b(b_bit), .sum(w_s0), .carry(w_c0));
  ha_cell u_ha1 (.a(w_s0), .b(r_carry), .sum(w_sum), .carry(w_c1));
  assign w_carry_next = w_c0 | w_c1;
  assign w_accept     = (r_state == SHIFT) && bit_valid;
  assign w_last       = r_cnt == CW'(WIDTH - 1);
  // the newest sum bit completes the word on the final accept, so result is taken from the shift input
  assign w_sh         = {w_sum, r_sr};
`ifdef SERIAL_ADD_SATURATE_EN
  assign w_res = w_carry_next ? '1 : w_sh;
`else
  assign w_res = w_sh;
`endif
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? SHIFT : IDLE;
      SHIFT:   w_next = (w_accept && w_last) ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else if (ena) r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_sr      <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (ena) begin
      if (r_state == IDLE && start) begin
        r_carry <= 1'b0;
        r_cnt   <= '0;
        r_sr    <= '0;
      end else if (w_accept) begin
        r_carry <= w_carry_next;
        r_cnt   <= r_cnt + CW'(1);
        r_sr    <= w_sh[WIDTH-1:1];
        if (w_last) begin
          result    <= w_res;
          carry_out <= w_carry_next;
        end
      end
    end
  end
endmodule
